// File: rtl/psum_quant_writer.sv
// rtl/psum_quant_writer.sv - drains psum rows, requantizes lanes to int8 and writes packed words to output BRAM

module psum_quant_writer #(
   parameter int COL               = 8,
   parameter int OUT_DATA_WIDTH    = 32,
   parameter int IN_DATA_WIDTH     = 8,
   parameter int P_BRAM_ADDR_WIDTH = 5,
   parameter int O_BRAM_ADDR_WIDTH = 7,
   parameter int O_BRAM_DATA_WIDTH = 32,
   parameter int SHIFT             = 11
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                start,
   input  logic [P_BRAM_ADDR_WIDTH:0]          num_rows,
   input  logic [O_BRAM_ADDR_WIDTH-1:0]        o_base_addr,
   output logic                                psum_rd_en,
   output logic [P_BRAM_ADDR_WIDTH-1:0]        psum_rd_addr,
   input  logic [COL*OUT_DATA_WIDTH-1:0]       psum_dout,
   output logic                                o_en,
   output logic                                o_we,
   output logic [O_BRAM_ADDR_WIDTH-1:0]        o_addr,
   output logic [O_BRAM_DATA_WIDTH-1:0]        o_din,
   output logic                                busy,
   output logic                                done
);

   localparam int WORDS = (COL * IN_DATA_WIDTH) / O_BRAM_DATA_WIDTH;
   localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int QW    = COL * IN_DATA_WIDTH;

   localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);

   // Saturation bounds of the quantized lane, held at psum width for signed compares
   localparam logic signed [OUT_DATA_WIDTH-1:0] QMAX = OUT_DATA_WIDTH'((1 << (IN_DATA_WIDTH - 1)) - 1);
   localparam logic signed [OUT_DATA_WIDTH-1:0] QMIN = ~QMAX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_DONE
   } state_t;

   state_t                          state_q;
   logic [P_BRAM_ADDR_WIDTH-1:0]    row_q;
   logic [P_BRAM_ADDR_WIDTH:0]      num_rows_q;
   logic [WW-1:0]                   w_q;
   logic [O_BRAM_ADDR_WIDTH-1:0]    wptr_q;
   logic [QW-1:0]                   q_reg_q;
   logic [QW-1:0]                   q_row_d;

   logic                            psum_rd_en_q;
   logic [P_BRAM_ADDR_WIDTH-1:0]    psum_rd_addr_q;
   logic                            o_en_q;
   logic                            o_we_q;
   logic [O_BRAM_ADDR_WIDTH-1:0]    o_addr_q;
   logic [O_BRAM_DATA_WIDTH-1:0]    o_din_q;
   logic                            busy_q;
   logic                            done_q;

   logic                            last_row;

   // Arithmetic shift, round half to even using guard/round/sticky bits, then saturate
   function automatic logic [IN_DATA_WIDTH-1:0] requant(input logic [OUT_DATA_WIDTH-1:0] x);
      logic signed [OUT_DATA_WIDTH-1:0] q;
      logic signed [OUT_DATA_WIDTH-1:0] y;
      logic                             g;
      logic                             r;
      logic                             s;
      logic                             inc;
      q   = $signed(x) >>> SHIFT;
      g   = x[SHIFT-1];
      r   = x[SHIFT-2];
      s   = |x[SHIFT-3:0];
      inc = g & (r | s | q[0]);
      y   = q + {{(OUT_DATA_WIDTH-1){1'b0}}, inc};
      if (y > QMAX) begin
         y = QMAX;
      end else if (y < QMIN) begin
         y = QMIN;
      end
      return y[IN_DATA_WIDTH-1:0];
   endfunction

   // Quantize every lane of the row currently on the psum read port
   always_comb begin
      q_row_d = '0;
      for (int k = 0; k < COL; k++) begin
         q_row_d[IN_DATA_WIDTH*k +: IN_DATA_WIDTH] = requant(psum_dout[OUT_DATA_WIDTH*k +: OUT_DATA_WIDTH]);
      end
   end

   assign last_row = ({1'b0, row_q} == (num_rows_q - 1'b1));

   // Drain FSM; every output is a register updated alongside the state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= S_IDLE;
         row_q          <= '0;
         num_rows_q     <= '0;
         w_q            <= '0;
         wptr_q         <= '0;
         q_reg_q        <= '0;
         psum_rd_en_q   <= 1'b0;
         psum_rd_addr_q <= '0;
         o_en_q         <= 1'b0;
         o_we_q         <= 1'b0;
         o_addr_q       <= '0;
         o_din_q        <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         psum_rd_en_q <= 1'b0;
         o_en_q       <= 1'b0;
         o_we_q       <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (num_rows != '0) begin
                     num_rows_q     <= num_rows;
                     wptr_q         <= o_base_addr;
                     row_q          <= '0;
                     psum_rd_en_q   <= 1'b1;
                     psum_rd_addr_q <= '0;
                     busy_q         <= 1'b1;
                     state_q        <= S_RD;
                  end else begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end
               end
            end
            S_RD: begin
               state_q <= S_CAP;
            end
            S_CAP: begin
               // First word goes straight from the quantizer so the write starts next cycle
               q_reg_q  <= q_row_d;
               w_q      <= '0;
               o_en_q   <= 1'b1;
               o_we_q   <= 1'b1;
               o_addr_q <= wptr_q;
               o_din_q  <= q_row_d[O_BRAM_DATA_WIDTH-1:0];
               wptr_q   <= wptr_q + 1'b1;
               state_q  <= S_WR;
            end
            S_WR: begin
               if (w_q == W_LAST) begin
                  if (last_row) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     row_q          <= row_q + 1'b1;
                     psum_rd_en_q   <= 1'b1;
                     psum_rd_addr_q <= row_q + 1'b1;
                     state_q        <= S_RD;
                  end
               end else begin
                  w_q      <= w_q + 1'b1;
                  o_en_q   <= 1'b1;
                  o_we_q   <= 1'b1;
                  o_addr_q <= wptr_q;
                  o_din_q  <= q_reg_q[O_BRAM_DATA_WIDTH*int'(w_q) + O_BRAM_DATA_WIDTH +: O_BRAM_DATA_WIDTH];
                  wptr_q   <= wptr_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign psum_rd_en   = psum_rd_en_q;
   assign psum_rd_addr = psum_rd_addr_q;
   assign o_en         = o_en_q;
   assign o_we         = o_we_q;
   assign o_addr       = o_addr_q;
   assign o_din        = o_din_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
